// File: rtl/spi_tx_pkg.sv
// Shared types and limits for the SPI TX burst sequencer.
package spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_DONE,
    COMPLETE
  } spi_seq_state_t;

  localparam int SPI_SEQ_MAX_RD_LAT = 3;

endpackage

// File: rtl/spi_edge_detect.sv
// One-bit rising-edge detector; o_rise is high in the cycle the input first reads high.
module spi_edge_detect (
  input  logic i_clock,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) level_q <= 1'b0;
    else          level_q <= i_level;
  end

  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/spi_tx_burst_seq.sv
// Burst sequencer: walks a word-store address window and hands each word to the SPI TX engine.
// Optional abort input enabled by defining SPI_TX_BURST_SEQ_ABORT_EN.
module spi_tx_burst_seq
  import spi_tx_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = ADDR_W + 1,
  parameter int RD_LAT = 1
) (
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_done,
`ifdef SPI_TX_BURST_SEQ_ABORT_EN
  input  logic              i_abort,
`endif
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_send,
  output logic              o_busy,
  output logic              o_burst_done,
  output logic [LEN_W-1:0]  o_word_idx
);

  if (RD_LAT < 0 || RD_LAT > SPI_SEQ_MAX_RD_LAT) begin : g_bad_rd_lat
    $error("spi_tx_burst_seq: RD_LAT out of range");
  end

  // With zero read latency the word is valid as soon as the address is driven.
  localparam spi_seq_state_t WORD_ENTRY = (RD_LAT == 0) ? SEND : FETCH;
  localparam logic [1:0]     LAT_LAST   = 2'((RD_LAT == 0) ? 0 : RD_LAT - 1);

  spi_seq_state_t    state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        lat_cnt;
  logic              start_rise;
  logic              last_word;
  logic              abort_now;
  logic              abort_pend;

  spi_edge_detect u_start_edge (
    .i_clock (i_clock),
    .i_rst_n (i_rst_n),
    .i_level (i_start),
    .o_rise  (start_rise)
  );

`ifdef SPI_TX_BURST_SEQ_ABORT_EN
  logic abort_q;

  assign abort_now  = i_abort;
  assign abort_pend = abort_q | i_abort;

  // A request seen while waiting is held until that word's done arrives.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) abort_q <= 1'b0;
    else          abort_q <= (state_q == WAIT_DONE) && (state_d == WAIT_DONE) && abort_pend;
  end
`else
  assign abort_now  = 1'b0;
  assign abort_pend = 1'b0;
`endif

  assign last_word = (o_word_idx + LEN_W'(1)) >= len_q;

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_rise) state_d = (i_len == '0) ? COMPLETE : WORD_ENTRY;
      end
      FETCH: begin
        if (abort_now)               state_d = COMPLETE;
        else if (lat_cnt == LAT_LAST) state_d = SEND;
      end
      SEND: begin
        state_d = abort_now ? COMPLETE : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_done) state_d = (last_word || abort_pend) ? COMPLETE : WORD_ENTRY;
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      lat_cnt      <= '0;
      o_raddr      <= '0;
      o_send       <= 1'b0;
      o_busy       <= 1'b0;
      o_burst_done <= 1'b0;
      o_word_idx   <= '0;
    end else begin
      state_q      <= state_d;
      o_send       <= (state_d == SEND);
      o_busy       <= (state_d != IDLE);
      o_burst_done <= (state_d == COMPLETE);
      lat_cnt      <= (state_q == FETCH && state_d == FETCH) ? lat_cnt + 2'd1 : 2'd0;

      case (state_q)
        IDLE: begin
          if (start_rise) begin
            len_q <= i_len;
            if (i_len != '0) begin
              o_raddr    <= i_start_addr;
              o_word_idx <= '0;
            end
          end
        end
        WAIT_DONE: begin
          if (state_d == WORD_ENTRY) begin
            o_raddr    <= o_raddr + ADDR_W'(1);
            o_word_idx <= o_word_idx + LEN_W'(1);
          end
        end
        COMPLETE: o_word_idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_burst_seq.sv
// Self-checking bench for spi_tx_burst_seq: directed and randomized bursts against a timing model.
module tb_spi_tx_burst_seq;

  localparam int ADDR_W = 4;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int RD_LAT = 1;

  logic              i_clock = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic [ADDR_W-1:0] i_start_addr;
  logic [LEN_W-1:0]  i_len;
  logic              i_done;
`ifdef SPI_TX_BURST_SEQ_ABORT_EN
  logic              i_abort;
`endif
  logic [ADDR_W-1:0] o_raddr;
  logic              o_send;
  logic              o_busy;
  logic              o_burst_done;
  logic [LEN_W-1:0]  o_word_idx;

  int vectors     = 0;
  int miscompares = 0;

  always #5 i_clock = ~i_clock;

  spi_tx_burst_seq #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .i_clock      (i_clock),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .i_len        (i_len),
    .i_done       (i_done),
`ifdef SPI_TX_BURST_SEQ_ABORT_EN
    .i_abort      (i_abort),
`endif
    .o_raddr      (o_raddr),
    .o_send       (o_send),
    .o_busy       (o_busy),
    .o_burst_done (o_burst_done),
    .o_word_idx   (o_word_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_send"},  32'(o_send), 32'(0));
    check({tag, "_busy"},  32'(o_busy), 32'(0));
    check({tag, "_bdone"}, 32'(o_burst_done), 32'(0));
    check({tag, "_widx"},  32'(o_word_idx), 32'(0));
  endtask

  // Model: first send at T+1+RD_LAT; a done driven in cycle D gives the next send at D+1+RD_LAT,
  // or burst_done at D+1 after the last word. mode 0 pulses start, 1 holds it, 2 re-toggles mid-burst.
  task automatic run_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                           input int gmin, input int gmax, input int mode, input bit noise,
                           input int abort_word);
    int c         = 0;
    int next_send = -1;
    int done_at   = -1;
    int abort_at  = -1;
    int bd        = -1;
    int sends     = 0;
    bit finished  = 1'b0;
    bit aborting  = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W-1:0] exp_last;

    i_start = 1'b0;
    i_done  = 1'b0;
    tick();
    prev_addr    = o_raddr;
    i_start_addr = addr;
    i_len        = len;
    i_start      = 1'b1;
    if (len == '0) bd = 1;
    else           next_send = 1 + RD_LAT;

    while (!finished && c < 400) begin
      tick();
      c++;
      i_done = 1'b0;
`ifdef SPI_TX_BURST_SEQ_ABORT_EN
      i_abort = 1'b0;
`endif
      if (mode == 0)      i_start = 1'b0;
      else if (mode == 2) i_start = (c >= 3 && c < 6);

      check("busy",       32'(o_busy),       32'(1));
      check("send",       32'(o_send),       32'(c == next_send));
      check("burst_done", 32'(o_burst_done), 32'(c == bd));

      if (c == next_send) begin
        check("raddr",    32'(o_raddr),    32'((int'(addr) + sends) % (1 << ADDR_W)));
        check("word_idx", 32'(o_word_idx), 32'(sends));
        if (sends == abort_word) begin
          abort_at = c + 1;
          done_at  = c + int'($urandom_range(gmax, 2));
        end else begin
          done_at  = c + int'($urandom_range(gmax, gmin));
        end
        sends++;
        next_send = -1;
        if (noise) i_done = 1'b1;
      end

      if (c == abort_at) begin
`ifdef SPI_TX_BURST_SEQ_ABORT_EN
        i_abort = 1'b1;
`endif
        aborting = 1'b1;
      end

      if (c == done_at) begin
        i_done  = 1'b1;
        done_at = -1;
        if (sends == int'(len) || aborting) bd = c + 1;
        else                                next_send = c + 1 + RD_LAT;
      end

      if (c == bd) finished = 1'b1;
    end
    check("burst_finished", 32'(finished), 32'(1));

    i_done = 1'b0;
    if (mode == 0) i_start = 1'b0;
    tick();
    exp_last = (len == '0) ? prev_addr : ADDR_W'(int'(addr) + sends - 1);
    check_idle("post");
    check("post_raddr", 32'(o_raddr), 32'(exp_last));

    if (mode == 1) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check_idle("held_start");
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    bit seen_send;

    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_start_addr = '0;
    i_len        = '0;
    i_done       = 1'b0;
`ifdef SPI_TX_BURST_SEQ_ABORT_EN
    i_abort      = 1'b0;
`endif

    tick();
    tick();
    check_idle("reset");
    check("reset_raddr", 32'(o_raddr), 32'(0));
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_idle("idle");
    end

    run_burst(4'd3,  5'd5,  4, 4, 0, 1'b0, -1);
    run_burst(4'd14, 5'd16, 1, 3, 0, 1'b0, -1);
    run_burst(4'd9,  5'd0,  1, 1, 0, 1'b0, -1);

    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    check_idle("idle_done");
    tick();
    check_idle("idle_done2");

    run_burst(4'd2, 5'd3, 1, 2, 0, 1'b1, -1);
    run_burst(4'd7, 5'd4, 1, 3, 1, 1'b0, -1);
    run_burst(4'd0, 5'd6, 3, 5, 2, 1'b0, -1);

    // Reset while waiting for done aborts the burst; the stale done must not restart anything.
    i_start = 1'b0;
    tick();
    i_start_addr = 4'd5;
    i_len        = 5'd4;
    i_start      = 1'b1;
    tick();
    i_start   = 1'b0;
    seen_send = o_send;
    for (int k = 0; k < 10 && !seen_send; k++) begin
      tick();
      seen_send = o_send;
    end
    check("rst_wait_send", 32'(seen_send), 32'(1));
    tick();
    i_rst_n = 1'b0;
    tick();
    check_idle("mid_reset");
    check("mid_reset_raddr", 32'(o_raddr), 32'(0));
    i_rst_n = 1'b1;
    i_done  = 1'b1;
    tick();
    i_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_idle("after_reset");
    end

`ifdef SPI_TX_BURST_SEQ_ABORT_EN
    run_burst(4'd1, 5'd6, 2, 4, 0, 1'b0, 2);
`endif

    for (int n = 0; n < 12; n++) begin
      run_burst(ADDR_W'($urandom), LEN_W'($urandom_range(16, 1)), 1,
                int'($urandom_range(5, 1)), 0, 1'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
